// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with a two-entry skid buffer and flush.
//            Optional stall counter enabled by macro ID_EX_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_op1,
    input  logic [DATA_WIDTH-1:0]     in_op2,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic                      in_alu_src,
    input  logic [2:0]                in_alu_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_reg_write,
    input  logic                      in_mem_write,
    input  logic                      in_branch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic [DATA_WIDTH-1:0]     out_op1,
    output logic [DATA_WIDTH-1:0]     out_op2,
    output logic [DATA_WIDTH-1:0]     out_imm,
    output logic                      out_alu_src,
    output logic [2:0]                out_alu_ctrl,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_reg_write,
    output logic                      out_mem_write,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]               stall_cnt,
`endif
    output logic                      out_branch
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     op1;
        logic [DATA_WIDTH-1:0]     op2;
        logic [DATA_WIDTH-1:0]     imm;
        logic                      alu_src;
        logic [2:0]                alu_ctrl;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_write;
        logic                      branch;
    } payload_t;

    payload_t r_main;
    payload_t r_skid;
    payload_t w_in;
    logic     r_main_valid;
    logic     r_skid_valid;
    logic     w_accept;
    logic     w_consume;

    assign w_in = '{pc: in_pc, op1: in_op1, op2: in_op2, imm: in_imm,
                    alu_src: in_alu_src, alu_ctrl: in_alu_ctrl, rd: in_rd,
                    reg_write: in_reg_write, mem_write: in_mem_write,
                    branch: in_branch};

    // Ready depends only on state, so downstream stalls never reach decode combinationally.
    assign in_ready  = ~r_skid_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid && w_consume) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_consume) begin
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main <= w_in;
            end
        end else if (w_accept) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid     = r_main_valid;
    assign out_pc        = r_main.pc;
    assign out_op1       = r_main.op1;
    assign out_op2       = r_main.op2;
    assign out_imm       = r_main.imm;
    assign out_alu_src   = r_main.alu_src;
    assign out_alu_ctrl  = r_main.alu_ctrl;
    assign out_rd        = r_main.rd;
    // Side-effecting controls are masked so a bubble can never write state.
    assign out_reg_write = r_main.reg_write & r_main_valid;
    assign out_mem_write = r_main.mem_write & r_main_valid;
    assign out_branch    = r_main.branch    & r_main_valid;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed self-checking bench for id_ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_op1, in_op2, in_imm;
    logic        in_alu_src;
    logic [2:0]  in_alu_ctrl;
    logic [4:0]  in_rd;
    logic        in_reg_write, in_mem_write, in_branch;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_op1, out_op2, out_imm;
    logic        out_alu_src;
    logic [2:0]  out_alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_write, out_branch;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op1(in_op1), .in_op2(in_op2), .in_imm(in_imm),
        .in_alu_src(in_alu_src), .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_mem_write(in_mem_write), .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_alu_src(out_alu_src), .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .out_branch(out_branch)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rw);
        in_valid     = v;
        in_pc        = pc;
        in_reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_op1 = '0; in_op2 = '0; in_imm = '0;
        in_alu_src = 1'b0; in_alu_ctrl = 3'b000; in_rd = '0;
        in_reg_write = 1'b0; in_mem_write = 1'b0; in_branch = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_reg_write", 64'(out_reg_write), 64'd0);
        rst_n = 1'b1;

        // Single instruction: op1=5, op2=3, sub
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b1);
        in_op1 = 32'd5; in_op2 = 32'd3; in_alu_ctrl = 3'b001; in_alu_src = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_op1", 64'(out_op1), 64'd5);
        check("t1_op2", 64'(out_op2), 64'd3);
        check("t1_alu_ctrl", 64'(out_alu_ctrl), 64'd1);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        check("t1_reg_write", 64'(out_reg_write), 64'd1);

        // Full-width passthrough of every field
        drive(1'b1, 32'hDEAD_BEEC, 1'b0);
        in_op1 = 32'h8000_0001; in_op2 = 32'hFFFF_FFFF; in_imm = 32'hFFFF_FFF0;
        in_alu_src = 1'b1; in_alu_ctrl = 3'b111; in_rd = 5'd31;
        in_mem_write = 1'b1; in_branch = 1'b1;
        @(negedge clk);
        check("pt_pc", 64'(out_pc), 64'hDEAD_BEEC);
        check("pt_op1", 64'(out_op1), 64'h8000_0001);
        check("pt_op2", 64'(out_op2), 64'hFFFF_FFFF);
        check("pt_imm", 64'(out_imm), 64'hFFFF_FFF0);
        check("pt_alu_src", 64'(out_alu_src), 64'd1);
        check("pt_alu_ctrl", 64'(out_alu_ctrl), 64'd7);
        check("pt_rd", 64'(out_rd), 64'd31);
        check("pt_mem_write", 64'(out_mem_write), 64'd1);
        check("pt_branch", 64'(out_branch), 64'd1);
        check("pt_reg_write", 64'(out_reg_write), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("bubble_valid", 64'(out_valid), 64'd0);
        check("bubble_mem_write", 64'(out_mem_write), 64'd0);
        check("bubble_branch", 64'(out_branch), 64'd0);
        in_mem_write = 1'b0; in_branch = 1'b0;

        // Back-to-back stream pc=0..28
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_pc", 64'(out_pc), 64'(4 * (i - 1)));
            end
            if (i < 8) drive(1'b1, 32'(4 * i), 1'b0);
            else       in_valid = 1'b0;
            @(negedge clk);
        end
        check("stream_drain", 64'(out_valid), 64'd0);

        // Stall with two entries, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 1'b0);
        @(negedge clk);
        check("stall_ready_1", 64'(in_ready), 64'd1);
        check("stall_pc_1", 64'(out_pc), 64'h10);
        drive(1'b1, 32'h14, 1'b0);
        @(negedge clk);
        check("stall_ready_2", 64'(in_ready), 64'd0);
        check("stall_pc_hold", 64'(out_pc), 64'h10);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_pc_14", 64'(out_pc), 64'h14);
        check("drain_valid_14", 64'(out_valid), 64'd1);
        check("drain_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("drain_empty", 64'(out_valid), 64'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h24, 1'b1);
        @(negedge clk);
        check("fl_full_ready", 64'(in_ready), 64'd0);
        check("fl_full_rw", 64'(out_reg_write), 64'd1);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_reg_write", 64'(out_reg_write), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h40, 1'b0);
        @(negedge clk);
        check("fl_next_valid", 64'(out_valid), 64'd1);
        check("fl_next_pc", 64'(out_pc), 64'h40);
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_alone", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h34, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("ar_pre_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_pc", 64'(out_pc), 64'd0);
`ifdef ID_EX_STALL_CNT_EN
        check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ID_EX_STALL_CNT_EN
        // Stall counting and saturation
        drive(1'b1, 32'h50, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("sc_seven", 64'(stall_cnt), 64'd7);
        dut.r_stall_cnt = 32'hFFFF_FFFE;
        repeat (2) @(negedge clk);
        check("sc_saturate", 64'(stall_cnt), 64'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that registers decoded operands and control, and presents them to the ALU operand/control inputs.
- Outputs feed the ALU directly: op1, rs2 operand, immediate, operand select and 3-bit ALU control.
- Two-entry skid buffer with a valid/ready handshake, so stalls from EX/MEM never create a combinational ready path back to decode.
- Synchronous flush squashes wrong-path instructions after a taken branch.

Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC fields.
- REG_ADDR_WIDTH, 5, width of destination register index.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_pc  input  DATA_WIDTH  instruction PC
- in_op1  input  DATA_WIDTH  rs1 data
- in_op2  input  DATA_WIDTH  rs2 data
- in_imm  input  DATA_WIDTH  sign-extended immediate
- in_alu_src  input  1  1 selects immediate as ALU operand 2
- in_alu_ctrl  input  3  ALU operation code (000 add, 001 sub)
- in_rd  input  REG_ADDR_WIDTH  destination register
- in_reg_write  input  1  writes rd
- in_mem_write  input  1  store
- in_branch  input  1  branch instruction
- out_valid  output  1  held instruction valid
- out_ready  input  1  EX/MEM accepts
- out_pc, out_op1, out_op2, out_imm  output  DATA_WIDTH  registered copies
- out_alu_src  output  1
- out_alu_ctrl  output  3
- out_rd  output  REG_ADDR_WIDTH
- out_reg_write, out_mem_write, out_branch  output  1  gated with out_valid

Behaviour:
- Reset (rst_n low, asynchronous): main and skid entries invalid and all payload zero. Outputs: out_valid=0, every out_* = 0, in_ready=1.
- Handshake: accept = in_valid & in_ready; consume = out_valid & out_ready. in_valid is a don't-care when in_ready=0; payload is sampled only on accept.
- Latency: an instruction accepted at edge N is visible on out_* after edge N (1 cycle). Throughput is 1 per cycle while out_ready=1.
- Entry update on each edge, priority order:
  - flush=1: main_valid=0, skid_valid=0. Any same-cycle accept is discarded and any same-cycle consume is still counted by downstream. in_ready=1 next cycle.
  - main empty, or consume with skid empty: an accepted instruction loads main.
  - main full, no consume, accept: instruction loads skid; in_ready=0 next cycle.
  - skid full and consume: skid moves to main; in_ready=1 next cycle. No accept is possible this cycle because in_ready=0.
  - consume with no accept and skid empty: main_valid=0.
- Ordering is strict FIFO; an entry is never dropped except by flush or reset.
- Bubble safety: out_reg_write, out_mem_write and out_branch are forced 0 whenever out_valid=0. Data fields may hold stale values while invalid.
- Reset mid-operation clears both entries immediately, regardless of clk.
- No arithmetic in this block; all fields pass through at full width with no truncation.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits.
  - Increments on every cycle with out_valid=1 and out_ready=0.
  - Saturates at 0xFFFFFFFF and holds that value.
  - Cleared by reset only; flush has no effect on it.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset release, then in_valid=1 with op1=5, op2=3, alu_ctrl=001, alu_src=0, out_ready=1 -> next cycle out_valid=1, out_op1=5, out_op2=3, out_alu_ctrl=001, in_ready=1.
- Back-to-back stream of 8 instructions with pc=0,4,...,28 and out_ready=1 -> out_pc sequence 0..28 on consecutive cycles, no gaps.
- out_ready=0 while sending pc=0x10 then pc=0x14 -> in_ready=0 after the 2nd accept. Raise out_ready -> 0x10 then 0x14 delivered in order, and in_ready returns to 1 one cycle after 0x10 is consumed.
- Both entries full (pc=0x20, 0x24) with in_reg_write=1, flush=1 for one cycle -> out_valid=0, out_reg_write=0, in_ready=1 next cycle. The next accepted pc=0x40 appears alone.
- rst_n asserted low mid-stall with both entries full -> out_valid=0 and in_ready=1 without waiting for a clock edge. With ID_EX_STALL_CNT_EN, stall_cnt=0.
- ID_EX_STALL_CNT_EN defined, out_valid=1 with out_ready=0 held for 7 cycles -> stall_cnt=7. Preloaded at 0xFFFFFFFE, two further stall cycles -> 0xFFFFFFFF.
